sysid_regs: RTL and testbench

Parametrised Avalon-MM system-identification peripheral, successor to the fixed two-word system ID slave. It exposes the build ID, build timestamp and clock frequency as read-only registers. It adds a free-running 64-bit uptime counter with atomic high/low readout, a writable scratch register, and a control register. The block sits on the Nios II data master interconnect as a control slave with fixed read latency 1.

---
 rtl/sysid_pkg.sv | 33 +++
 rtl/sysid_uptime_counter.sv | 48 ++++
 rtl/sysid_regs.sv | 115 +++++++++++
 tb/tb_sysid_regs.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-identification peripheral:
// word addresses, CTRL bit positions and the uptime value type.
package sysid_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
    localparam logic [2:0] ADDR_CLK_FREQ  = 3'd5;
    localparam logic [2:0] ADDR_CTRL      = 3'd6;
    localparam logic [2:0] ADDR_RSVD      = 3'd7;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_FREEZE = 1;

    typedef logic [63:0] uptime_t;

    // Merge new write data into an old word, lane by lane.
    function automatic logic [31:0] merge_bytes(input logic [31:0] oldWord,
                                                input logic [31:0] newWord,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[i*8 +: 8] = newWord[i*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit uptime counter with a high-word shadow that is
// captured whenever the low word is read, so a LO-then-HI read pair is
// coherent. Only present when SYSID_UPTIME_EN is defined.
`ifdef SYSID_UPTIME_EN
module sysid_uptime_counter
    import sysid_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        freeze,
    input  logic        snap,
    output logic [31:0] lo,
    output logic [31:0] hi_shadow
);

    uptime_t     count_q;
    uptime_t     count_d;
    logic [31:0] shadow_q;

    // Clear wins over freeze so a combined write leaves the counter zeroed and held.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (!freeze) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter and shadow state; the shadow only moves on a low-word read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            count_q <= count_d;
            if (snap) begin
                shadow_q <= count_q[63:32];
            end
        end
    end

    assign lo        = count_q[31:0];
    assign hi_shadow = shadow_q;

endmodule
`endif

// File: rtl/sysid_regs.sv
// Avalon-MM system-identification slave with fixed read latency 1.
// Optional uptime counter / CTRL register enabled by macro SYSID_UPTIME_EN;
// without it words 2, 3 and 6 read 0 and ignore writes.
module sysid_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h5148_F2F9,
    parameter logic [31:0] CLK_FREQ_HZ   = 32'd50_000_000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic        wrEn;
    logic [31:0] scratch_q;
    logic [31:0] scratch_d;
    logic [31:0] readdata_q;
    logic [31:0] readdata_d;
    logic        readdatavalid_q;

    // A read in the same cycle takes the bus; the write is dropped.
    assign wrEn = write && !read;

`ifdef SYSID_UPTIME_EN
    logic        freeze_q;
    logic        ctrlWr;
    logic        clearPulse;
    logic        snap;
    logic [31:0] uptimeLo;
    logic [31:0] uptimeHi;
    logic [31:0] ctrlRead;

    assign ctrlWr     = wrEn && (address == ADDR_CTRL) && byteenable[0];
    assign clearPulse = ctrlWr && writedata[CTRL_CLEAR];
    assign snap       = read && (address == ADDR_UPTIME_LO);

    sysid_uptime_counter u_uptime (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clearPulse),
        .freeze    (freeze_q),
        .snap      (snap),
        .lo        (uptimeLo),
        .hi_shadow (uptimeHi)
    );

    // FREEZE is the only stored CTRL bit; CLEAR acts as a one-cycle pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freeze_q <= 1'b0;
        end else if (ctrlWr) begin
            freeze_q <= writedata[CTRL_FREEZE];
        end
    end

    // CTRL readback exposes FREEZE only; CLEAR and upper bits read 0.
    always_comb begin
        ctrlRead              = '0;
        ctrlRead[CTRL_FREEZE] = freeze_q;
    end
`endif

    // Scratch next value with per-lane write enables.
    always_comb begin
        scratch_d = scratch_q;
        if (wrEn && (address == ADDR_SCRATCH)) begin
            scratch_d = merge_bytes(scratch_q, writedata, byteenable);
        end
    end

    // Read mux; data is forced to 0 when no read is accepted.
    always_comb begin
        readdata_d = '0;
        if (read) begin
            case (address)
                ADDR_ID:        readdata_d = SYSTEM_ID;
                ADDR_TIMESTAMP: readdata_d = TIMESTAMP;
`ifdef SYSID_UPTIME_EN
                ADDR_UPTIME_LO: readdata_d = uptimeLo;
                ADDR_UPTIME_HI: readdata_d = uptimeHi;
                ADDR_CTRL:      readdata_d = ctrlRead;
`endif
                ADDR_SCRATCH:   readdata_d = scratch_q;
                ADDR_CLK_FREQ:  readdata_d = CLK_FREQ_HZ;
                default:        readdata_d = '0;
            endcase
        end
    end

    // Registered scratch and read response; reset discards any pending response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q       <= SCRATCH_RESET;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            scratch_q       <= scratch_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= read;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_sysid_regs.sv
// Self-checking bench for sysid_regs. Covers the default build and, when
// SYSID_UPTIME_EN is defined, the uptime counter / CTRL behaviour.
module tb_sysid_regs;

    logic        clock;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    sysid_regs dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one value and report a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one bus cycle (called just after a rising edge), then return
    // just after the next rising edge with the bus idle again.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] addr,
                                 input logic [31:0] wd, input logic [3:0] be);
        read       = rd;
        write      = wr;
        address    = addr;
        writedata  = wd;
        byteenable = be;
        @(posedge clock);
        #1;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        end
    endtask

    // Read a word and check both response signals.
    task automatic readCheck(input string name, input logic [2:0] addr,
                             input logic [31:0] expData);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0);
        checkOutput({name, "_valid"}, {31'b0, readdatavalid}, 32'd1);
        checkOutput({name, "_data"}, readdata, expData);
    endtask

    initial begin
        logic [31:0] firstLo;

        reset_n    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;

        // Reset state
        #3;
        checkOutput("reset_valid", {31'b0, readdatavalid}, 32'd0);
        checkOutput("reset_data", readdata, 32'd0);
        #19;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // One table entry per bus cycle; response is checked right after that cycle.
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h0,          4'h0, 1'b1, 32'h0000_0000});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h0,          4'h0, 1'b1, 32'h5148_F2F9});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h0,          4'h0, 1'b1, 32'd50_000_000});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'h0,          4'h0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 32'hFFFF_FFFF,  4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 32'h0000_1234,  4'h3, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0,          4'h0, 1'b1, 32'hFFFF_1234});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 32'h1234_5678,  4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h0,          4'h0, 1'b1, 32'h5148_F2F9});
        vecs.push_back('{1'b1, 1'b1, 3'd4, 32'hDEAD_BEEF,  4'hF, 1'b1, 32'hFFFF_1234});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0,          4'h0, 1'b1, 32'hFFFF_1234});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 32'hAAAA_5555,  4'hF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'd7, 32'h0,          4'h0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 32'hAABB_CCDD,  4'h4, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'd4, 32'h0,          4'h0, 1'b1, 32'hFFBB_1234});
        vecs.push_back('{1'b0, 1'b0, 3'd4, 32'h0,          4'h0, 1'b0, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be);
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, readdatavalid},
                        {31'b0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_data", i), readdata, vecs[i].expData);
        end

`ifdef SYSID_UPTIME_EN
        // Coherent 64-bit readout across a low-word carry boundary
        force dut.u_uptime.count_q = 64'h0000_0001_FFFF_FFFF;
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        release dut.u_uptime.count_q;
        checkOutput("uptime_lo_preload", readdata, 32'hFFFF_FFFF);
        idleCycles(9);
        readCheck("uptime_hi_shadow", 3'd3, 32'h0000_0001);

        // CLEAR alone: next read sees 0
        applyStimulus(1'b0, 1'b1, 3'd6, 32'h1, 4'h1);
        readCheck("clear_next_read", 3'd2, 32'h0);

        // CLEAR+FREEZE: zeroed and held; CTRL reads back FREEZE only
        applyStimulus(1'b0, 1'b1, 3'd6, 32'h3, 4'h1);
        idleCycles(20);
        readCheck("frozen_lo_a", 3'd2, 32'h0);
        readCheck("frozen_lo_b", 3'd2, 32'h0);
        readCheck("ctrl_readback", 3'd6, 32'h2);

        // CTRL write without byteenable[0] is ignored
        applyStimulus(1'b0, 1'b1, 3'd6, 32'h0, 4'hE);
        readCheck("ctrl_be_ignored", 3'd6, 32'h2);

        // Unfreeze: counter resumes from 0
        applyStimulus(1'b0, 1'b1, 3'd6, 32'h0, 4'h1);
        idleCycles(5);
        readCheck("resume_lo_a", 3'd2, 32'd5);
        readCheck("resume_lo_b", 3'd2, 32'd6);
`else
        // Uptime words and CTRL are absent in this build
        readCheck("absent_lo", 3'd2, 32'h0);
        readCheck("absent_hi", 3'd3, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'd6, 32'h3, 4'hF);
        readCheck("absent_ctrl", 3'd6, 32'h0);
        firstLo = 32'h0;
        applyStimulus(1'b0, 1'b1, 3'd6, 32'h1, 4'hF);
        readCheck("absent_lo_after_clear", 3'd2, firstLo);
`endif

        // Reset asserted mid-read: response dropped, outputs cleared at once
        read    = 1'b1;
        address = 3'd1;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_valid_now", {31'b0, readdatavalid}, 32'd0);
        checkOutput("midreset_data_now", readdata, 32'd0);
        @(posedge clock);
        #1;
        read    = 1'b0;
        address = '0;
        checkOutput("midreset_valid_edge", {31'b0, readdatavalid}, 32'd0);
        #4;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("postreset_valid", {31'b0, readdatavalid}, 32'd0);
        checkOutput("postreset_data", readdata, 32'd0);
        readCheck("scratch_after_reset", 3'd4, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
